// File: rtl/csr_encoder_if.sv
// csr_encoder_if: dense-element input stream and CSR RAM write bus of the CSR encoder
interface csr_encoder_if #(
  parameter int SP_AW  = 14,
  parameter int ROW_AW = 10
);
  logic              start;
  logic [31:0]       din;
  logic              din_valid;
  logic              din_ready;
  logic              sp_we;
  logic [SP_AW-1:0]  sp_addr;
  logic [31:0]       sp_data;
  logic [31:0]       col_data;
  logic              row_we;
  logic [ROW_AW-1:0] row_addr;
  logic [31:0]       row_data;
  logic [SP_AW:0]    nnz;
  logic              busy;
  logic              done;
  logic              ovf;
  modport master (
    output start, din, din_valid,
    input  din_ready, sp_we, sp_addr, sp_data, col_data, row_we, row_addr, row_data, nnz, busy, done, ovf
  );
  modport slave (
    input  start, din, din_valid,
    output din_ready, sp_we, sp_addr, sp_data, col_data, row_we, row_addr, row_data, nnz, busy, done, ovf
  );
endinterface

// File: rtl/csr_encoder.sv
// csr_encoder: turns a row-major dense matrix stream into CSR value/column/row-pointer RAM writes
module csr_encoder #(
  parameter int N_ROWS = 560,
  parameter int N_COLS = 560,
  parameter int SP_AW  = 14,
  parameter int ROW_AW = 10
) (
  input logic         clk,
  input logic         rst,
  csr_encoder_if.slave bus
);
  localparam int CW = N_COLS > 1 ? $clog2(N_COLS) : 1;
  typedef enum logic [1:0] {IDLE, START, RUN, DONE_S} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [ROW_AW-1:0] row_q, row_d;
  logic [SP_AW:0]    nnz_q, nnz_d;
  logic              ovf_q, ovf_d, done_q, done_d;
  logic              sp_we_q, sp_we_d;
  logic [SP_AW-1:0]  sp_addr_q, sp_addr_d;
  logic [31:0]       sp_data_q, sp_data_d, col_data_q, col_data_d;
  logic              row_we_q, row_we_d;
  logic [ROW_AW-1:0] row_addr_q, row_addr_d;
  logic [31:0]       row_data_q, row_data_d;
  logic              go, acc, nz, row_end, last;
  assign go      = bus.start && (state_q == IDLE || state_q == DONE_S);
  assign acc     = state_q == RUN && bus.din_valid;
  assign nz      = bus.din != '0;
  assign row_end = acc && col_q == CW'(N_COLS - 1);
  assign last    = row_end && row_q == ROW_AW'(N_ROWS - 1);
  always_ff @(posedge clk)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = go ? START : state_q == START ? RUN : last ? DONE_S : state_q == DONE_S ? IDLE : state_q;
  always_comb begin
    bus.din_ready = state_q == RUN;
    bus.busy      = state_q == START || state_q == RUN;
  end
  // nnz saturates at 2^SP_AW: its top bit marks the sparse RAMs as full
  always_comb begin
    sp_we_d    = acc && nz && !nnz_q[SP_AW];
    ovf_d      = !go && (ovf_q || (acc && nz && nnz_q[SP_AW]));
    nnz_d      = go ? '0 : nnz_q + {{SP_AW{1'b0}}, sp_we_d};
    sp_addr_d  = sp_we_d ? nnz_q[SP_AW-1:0] : sp_addr_q;
    sp_data_d  = sp_we_d ? bus.din : sp_data_q;
    col_data_d = sp_we_d ? 32'(col_q) : col_data_q;
    col_d      = go || row_end ? '0 : col_q + CW'(acc);
    row_d      = go ? '0 : row_q + ROW_AW'(row_end);
    row_we_d   = go || row_end;
    row_addr_d = go ? '0 : row_end ? row_q + ROW_AW'(1) : row_addr_q;
    row_data_d = go ? '0 : row_end ? 32'(nnz_d) : row_data_q;
    done_d     = !go && (done_q || state_q == DONE_S);
  end
  always_ff @(posedge clk)
    if (!rst) begin
      col_q      <= '0;
      row_q      <= '0;
      nnz_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      sp_we_q    <= 1'b0;
      sp_addr_q  <= '0;
      sp_data_q  <= '0;
      col_data_q <= '0;
      row_we_q   <= 1'b0;
      row_addr_q <= '0;
      row_data_q <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      nnz_q      <= nnz_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      sp_we_q    <= sp_we_d;
      sp_addr_q  <= sp_addr_d;
      sp_data_q  <= sp_data_d;
      col_data_q <= col_data_d;
      row_we_q   <= row_we_d;
      row_addr_q <= row_addr_d;
      row_data_q <= row_data_d;
    end
  assign bus.sp_we    = sp_we_q;
  assign bus.sp_addr  = sp_addr_q;
  assign bus.sp_data  = sp_data_q;
  assign bus.col_data = col_data_q;
  assign bus.row_we   = row_we_q;
  assign bus.row_addr = row_addr_q;
  assign bus.row_data = row_data_q;
  assign bus.nnz      = nnz_q;
  assign bus.done     = done_q;
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_csr_encoder.sv
// tb_csr_encoder: directed CSR encoding scenarios checked against a scoreboard built from the matrix
module tb_csr_encoder;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, din_valid = 1'b0;
  logic [31:0] din = '0;
  int          sel = 0;
  int          n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  csr_encoder_if #(.SP_AW(14), .ROW_AW(10)) ia ();
  csr_encoder_if #(.SP_AW(2),  .ROW_AW(2))  ib ();
  csr_encoder_if #(.SP_AW(6),  .ROW_AW(6))  ic ();
  csr_encoder #(.N_ROWS(3),  .N_COLS(4),  .SP_AW(14), .ROW_AW(10)) ua (.clk(clk), .rst(rst), .bus(ia));
  csr_encoder #(.N_ROWS(2),  .N_COLS(4),  .SP_AW(2),  .ROW_AW(2))  ub (.clk(clk), .rst(rst), .bus(ib));
  csr_encoder #(.N_ROWS(32), .N_COLS(32), .SP_AW(6),  .ROW_AW(6))  uc (.clk(clk), .rst(rst), .bus(ic));
  assign ia.start = start && sel == 0;
  assign ib.start = start && sel == 1;
  assign ic.start = start && sel == 2;
  assign ia.din_valid = din_valid && sel == 0;
  assign ib.din_valid = din_valid && sel == 1;
  assign ic.din_valid = din_valid && sel == 2;
  assign ia.din = din;
  assign ib.din = din;
  assign ic.din = din;
  logic        m_sp_we, m_row_we, m_busy, m_done, m_ovf, m_ready;
  logic [31:0] m_sp_addr, m_sp_data, m_col, m_row_addr, m_row_data, m_nnz;
  always_comb begin
    m_sp_we    = sel == 0 ? ia.sp_we : sel == 1 ? ib.sp_we : ic.sp_we;
    m_row_we   = sel == 0 ? ia.row_we : sel == 1 ? ib.row_we : ic.row_we;
    m_busy     = sel == 0 ? ia.busy : sel == 1 ? ib.busy : ic.busy;
    m_done     = sel == 0 ? ia.done : sel == 1 ? ib.done : ic.done;
    m_ovf      = sel == 0 ? ia.ovf : sel == 1 ? ib.ovf : ic.ovf;
    m_ready    = sel == 0 ? ia.din_ready : sel == 1 ? ib.din_ready : ic.din_ready;
    m_sp_addr  = sel == 0 ? 32'(ia.sp_addr) : sel == 1 ? 32'(ib.sp_addr) : 32'(ic.sp_addr);
    m_sp_data  = sel == 0 ? ia.sp_data : sel == 1 ? ib.sp_data : ic.sp_data;
    m_col      = sel == 0 ? ia.col_data : sel == 1 ? ib.col_data : ic.col_data;
    m_row_addr = sel == 0 ? 32'(ia.row_addr) : sel == 1 ? 32'(ib.row_addr) : 32'(ic.row_addr);
    m_row_data = sel == 0 ? ia.row_data : sel == 1 ? ib.row_data : ic.row_data;
    m_nnz      = sel == 0 ? 32'(ia.nnz) : sel == 1 ? 32'(ib.nnz) : 32'(ic.nnz);
  end
  typedef struct {int addr; int data; int col;} sp_t;
  typedef struct {int addr; int data;} rw_t;
  sp_t exp_sp[$];
  rw_t exp_row[$];
  int  mat[$];
  int  exp_nnz;
  bit  exp_ovf;
  sp_t se;
  rw_t re;
  bit  acc_prev;
  int  lit_addr[3] = '{0, 1, 2};
  int  lit_data[3] = '{5, 7, 9};
  int  lit_col[3]  = '{1, 3, 0};
  int  lit_row[4]  = '{0, 2, 2, 3};
  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [255:0] outs();
    return 256'({m_sp_we, m_row_we, m_busy, m_done, m_ovf, m_ready,
                 m_sp_addr, m_sp_data, m_col, m_row_addr, m_row_data, m_nnz});
  endfunction
  // CSR of the matrix straight from its definition: non-zeros in order until the RAMs are full
  function automatic void build(int nc, int cap);
    int cnt = 0;
    exp_sp.delete();
    exp_row.delete();
    exp_ovf = 1'b0;
    exp_row.push_back('{0, 0});
    foreach (mat[i]) begin
      if (mat[i] != 0) begin
        if (cnt < cap) begin
          exp_sp.push_back('{cnt, mat[i], i % nc});
          cnt++;
        end else exp_ovf = 1'b1;
      end
      if (i % nc == nc - 1) exp_row.push_back('{i / nc + 1, cnt});
    end
    exp_nnz = cnt;
  endfunction
  always @(posedge clk) acc_prev <= din_valid && m_ready;
  initial forever begin
    @(negedge clk);
    if (m_sp_we) begin
      if (exp_sp.size() == 0) chk("sp_unexpected", 256'(m_sp_we), 0);
      else begin
        se = exp_sp.pop_front();
        chk("sp_write", {acc_prev, m_sp_addr, m_sp_data, m_col, m_nnz},
            {1'b1, se.addr, se.data, se.col, se.addr + 1});
      end
    end
    if (m_row_we) begin
      if (exp_row.size() == 0) chk("row_unexpected", 256'(m_row_we), 0);
      else begin
        re = exp_row.pop_front();
        chk("row_write", {m_row_addr, m_row_data}, {re.addr, re.data});
      end
    end
  end
  task automatic beat(input logic [31:0] v, input bit s);
    int t = 0;
    din = v;
    din_valid = 1'b1;
    start = s;
    while (!m_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!m_ready) chk("ready_timeout", 256'(m_ready), 1);
    @(negedge clk);
    din_valid = 1'b0;
    start = 1'b0;
  endtask
  task automatic run(int s, int nc, int cap, bit bub, int start_at);
    sel = s;
    build(nc, cap);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_state", {m_busy, m_ready, m_done}, 3'b100);
    foreach (mat[i]) begin
      beat(mat[i], i == start_at);
      if (bub && i < mat.size() - 1) @(negedge clk);
    end
    chk("last_write_cycle", {m_done, m_busy}, 2'b00);
    @(negedge clk);
    chk("done", 256'(m_done), 1);
    chk("nnz", m_nnz, exp_nnz);
    chk("ovf", 256'(m_ovf), 256'(exp_ovf));
    chk("sp_pending", exp_sp.size(), 0);
    chk("row_pending", exp_row.size(), 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1 chk("reset_state", outs(), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    mat = '{0, 5, 0, 7, 0, 0, 0, 0, 9, 0, 0, 0};
    build(4, 16384);
    for (int i = 0; i < 3; i++)
      chk("model_sp", {exp_sp[i].addr, exp_sp[i].data, exp_sp[i].col}, {lit_addr[i], lit_data[i], lit_col[i]});
    for (int i = 0; i < 4; i++) chk("model_row", exp_row[i].data, lit_row[i]);
    run(0, 4, 16384, 1'b0, -1);
    repeat (3) @(negedge clk);
    chk("done_held", {m_done, m_busy}, 2'b10);
    run(0, 4, 16384, 1'b1, -1);
    run(0, 4, 16384, 1'b0, 6);
    mat = '{1, 2, 3, 4, 5, 6, 7, 8};
    build(4, 4);
    chk("model_ovf", {exp_ovf, exp_nnz, exp_row[1].data, exp_row[2].data}, {1'b1, 32'd4, 32'd4, 32'd4});
    run(1, 4, 4, 1'b0, -1);
    sel = 0;
    mat = '{0, 5, 0, 7, 0, 0, 0, 0, 9, 0, 0, 0};
    build(4, 16384);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) beat(mat[i], 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_reset", outs(), 0);
    rst = 1'b1;
    exp_sp.delete();
    exp_row.delete();
    run(0, 4, 16384, 1'b0, -1);
    mat.delete();
    for (int i = 0; i < 32 * 32; i++) mat.push_back(i / 32 == i % 32 ? 1 : 0);
    build(32, 64);
    chk("model_ident", {exp_sp.size(), exp_sp[31].col, exp_row[32].data}, {32'd32, 32'd31, 32'd32});
    run(2, 32, 64, 1'b0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
